cam_stream_gen: RTL and testbench

Synthesizable OV7670-style camera stream transmitter for the capture path. It drives the same pixel clock, HREF, VSYNC and 8-bit data bus that the camera capture block receives. Bench and board bring-up then use a deterministic source with no physical sensor attached. It sits in place of the camera on GPIO_1, or loops back internally, and emits YUV422-ordered frames carrying selectable test patterns.

---
 rtl/cam_gen_pkg.sv | 32 +++
 rtl/cam_gen_pattern.sv | 50 +++++
 rtl/cam_stream_gen.sv | 187 ++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_gen_pkg.sv
// cam_gen_pkg: shared types and constants for the OV7670-style test stream generator.
package cam_gen_pkg;

   localparam int unsigned X_W = 11;
   localparam int unsigned Y_W = 10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBACK  = 3'd2,
      ACTIVE = 3'd3,
      VFRONT = 3'd4
   } gen_state_t;

   localparam logic [1:0] PAT_RAMP    = 2'd0;
   localparam logic [1:0] PAT_CHECKER = 2'd1;
   localparam logic [1:0] PAT_SOLID   = 2'd2;
   localparam logic [1:0] PAT_MARKER  = 2'd3;

   localparam logic [7:0] CHROMA    = 8'h80;
   localparam logic [7:0] MARKER_BG = 8'h10;
   localparam logic [7:0] MARKER_FG = 8'hFF;

   // Per-frame pattern configuration, captured on VSYNC entry.
   typedef struct packed {
      logic [1:0]     sel;
      logic [7:0]     solid_y;
      logic [X_W-1:0] marker_x;
      logic [Y_W-1:0] marker_y;
   } pat_cfg_t;

endpackage

// File: rtl/cam_gen_pattern.sv
// cam_gen_pattern: combinational (x, y, pattern) -> luma lookup.
// Marker pattern present only when CAM_GEN_MARKER_EN is defined; otherwise
// pattern 3 falls back to the ramp.
module cam_gen_pattern
   import cam_gen_pkg::*;
(
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  pat_cfg_t       cfg,
   output logic [7:0]     luma_c
);

`ifdef CAM_GEN_MARKER_EN
   localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
   localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

   logic [X_W:0] x_w;
   logic [X_W:0] mx_w;
   logic [Y_W:0] y_w;
   logic [Y_W:0] my_w;
   logic         hit_c;

   // Marker window test, widened by one bit so +1 never wraps at the edges.
   always_comb begin
      x_w   = {1'b0, x};
      mx_w  = {1'b0, cfg.marker_x};
      y_w   = {1'b0, y};
      my_w  = {1'b0, cfg.marker_y};
      hit_c = ((x_w + X_ONE) >= mx_w) && (x_w <= (mx_w + X_ONE)) &&
              ((y_w + Y_ONE) >= my_w) && (y_w <= (my_w + Y_ONE));
   end
`else
   logic unused_c;
   assign unused_c = ^{x[X_W-1:8], y[Y_W-1:4], cfg.marker_x, cfg.marker_y};
`endif

   // Luma selection.
   always_comb begin
      luma_c = x[7:0];
      case (cfg.sel)
         PAT_CHECKER: luma_c = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
         PAT_SOLID:   luma_c = cfg.solid_y;
`ifdef CAM_GEN_MARKER_EN
         PAT_MARKER:  luma_c = hit_c ? MARKER_FG : MARKER_BG;
`endif
         default:     luma_c = x[7:0];
      endcase
   end

endmodule

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: deterministic OV7670-style pclk/vsync/href/data source.
// Optional marker pattern enabled by defining CAM_GEN_MARKER_EN.
module cam_stream_gen
   import cam_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned H_BLANK     = 288,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 17,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned PCLK_DIV    = 2
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [7:0]  solid_y,
   input  logic [10:0] marker_x,
   input  logic [9:0]  marker_y,
   output logic        pclk,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  data,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  frame_count
);

   localparam int unsigned LINE      = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned HREF_LEN  = 2 * H_ACTIVE;
   localparam int unsigned HALF      = PCLK_DIV / 2;
   localparam int unsigned DIV_W     = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;
   localparam int unsigned BYTE_W    = (LINE > 2) ? $clog2(LINE) : 1;
   localparam int unsigned MAX_VH    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
   localparam int unsigned MAX_AF    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int unsigned MAX_LINES = (MAX_VH > MAX_AF) ? MAX_VH : MAX_AF;
   localparam int unsigned LINE_W    = $clog2(MAX_LINES + 1);

   logic [1:0]        run_sync;
   logic              run_c;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick_c;

   gen_state_t        state;
   gen_state_t        nxt_state;
   logic [LINE_W-1:0] line_cnt;
   logic [LINE_W-1:0] nxt_line;
   logic [LINE_W-1:0] lines_lim_c;
   logic [BYTE_W-1:0] byte_cnt;
   logic [BYTE_W-1:0] nxt_byte;
   logic              frame_end_c;
   logic              nxt_href_c;
   logic [7:0]        nxt_data_c;
   logic [7:0]        luma_c;

   pat_cfg_t          cfg_in_c;
   pat_cfg_t          cfg_q;

   // Reset release synchronizer; assertion stays asynchronous.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) run_sync <= 2'b00;
      else          run_sync <= {run_sync[0], 1'b1};
   end

   assign run_c  = run_sync[1];
   assign tick_c = run_c && (div_cnt == DIV_W'(HALF - 1));

   // Pixel clock divider: pclk high for the first half, tick on its falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         pclk    <= 1'b0;
      end else if (run_c) begin
         if (div_cnt == DIV_W'(PCLK_DIV - 1)) begin
            div_cnt <= '0;
            pclk    <= 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == DIV_W'(HALF - 1)) pclk <= 1'b0;
         end
      end
   end

   // Number of lines (minus one) spent in the current state.
   always_comb begin
      lines_lim_c = '0;
      case (state)
         VSYNC:   lines_lim_c = LINE_W'(VSYNC_LINES - 1);
         VBACK:   lines_lim_c = LINE_W'(V_BACK - 1);
         ACTIVE:  lines_lim_c = LINE_W'(V_ACTIVE - 1);
         VFRONT:  lines_lim_c = LINE_W'(V_FRONT - 1);
         default: lines_lim_c = '0;
      endcase
   end

   // Next raster position and state, applied on the next tick.
   always_comb begin
      nxt_state   = state;
      nxt_line    = line_cnt;
      nxt_byte    = byte_cnt;
      frame_end_c = 1'b0;
      if (state == IDLE) begin
         if (enable) begin
            nxt_state = VSYNC;
            nxt_line  = '0;
            nxt_byte  = '0;
         end
      end else if (byte_cnt == BYTE_W'(LINE - 1)) begin
         nxt_byte = '0;
         if (line_cnt == lines_lim_c) begin
            nxt_line = '0;
            case (state)
               VSYNC:   nxt_state = VBACK;
               VBACK:   nxt_state = ACTIVE;
               ACTIVE:  nxt_state = VFRONT;
               VFRONT: begin
                  frame_end_c = 1'b1;
                  nxt_state   = enable ? VSYNC : IDLE;
               end
               default: nxt_state = IDLE;
            endcase
         end else begin
            nxt_line = line_cnt + 1'b1;
         end
      end else begin
         nxt_byte = byte_cnt + 1'b1;
      end
   end

   // Live pattern controls, captured only when a frame starts.
   always_comb begin
      cfg_in_c          = '0;
      cfg_in_c.sel      = pattern_sel;
      cfg_in_c.solid_y  = solid_y;
      cfg_in_c.marker_x = marker_x;
      cfg_in_c.marker_y = marker_y;
   end

   cam_gen_pattern u_pattern (
      .x      (X_W'(nxt_byte >> 1)),
      .y      (Y_W'(nxt_line)),
      .cfg    (cfg_q),
      .luma_c (luma_c)
   );

   // Byte bus value for the upcoming position: Y then fixed chroma.
   always_comb begin
      nxt_href_c = (nxt_state == ACTIVE) && (nxt_byte < BYTE_W'(HREF_LEN));
      nxt_data_c = 8'h00;
      if (nxt_href_c) nxt_data_c = nxt_byte[0] ? CHROMA : luma_c;
   end

   // Raster state and registered stream outputs, updated on tick edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         line_cnt    <= '0;
         byte_cnt    <= '0;
         vsync       <= 1'b0;
         href        <= 1'b0;
         data        <= 8'h00;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= 8'h00;
         cfg_q       <= '0;
      end else begin
         frame_done <= 1'b0;
         if (tick_c) begin
            state    <= nxt_state;
            line_cnt <= nxt_line;
            byte_cnt <= nxt_byte;
            vsync    <= (nxt_state == VSYNC);
            href     <= nxt_href_c;
            data     <= nxt_data_c;
            busy     <= (nxt_state != IDLE);
            if ((nxt_state == VSYNC) && (state != VSYNC)) cfg_q <= cfg_in_c;
            if (frame_end_c) begin
               frame_done  <= 1'b1;
               frame_count <= frame_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_stream_gen.sv
// tb_cam_stream_gen: scoreboard bench for cam_stream_gen (small raster and checker raster).
module tb_cam_stream_gen;

   logic        clk;
   logic        reset_n;

   logic        enable;
   logic [1:0]  pattern_sel;
   logic [7:0]  solid_y;
   logic [10:0] marker_x;
   logic [9:0]  marker_y;
   logic        pclk, vsync, href, busy, frame_done;
   logic [7:0]  data, frame_count;

   logic        enable_c;
   logic [1:0]  pattern_sel_c;
   logic        pclk_c, vsync_c, href_c, busy_c, frame_done_c;
   logic [7:0]  data_c, frame_count_c;

   int          n_cmp = 0;
   int          n_err = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  exp_qc[$];
   bit          mon_en = 1'b1;
   int          vs_cnt = 0;
   int          done_cnt = 0;
   int          done_cnt_c = 0;
   logic        pclk_d = 1'b0;
   logic        pclk_dc = 1'b0;

   cam_stream_gen #(
      .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .VSYNC_LINES(1),
      .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
      .solid_y(solid_y), .marker_x(marker_x), .marker_y(marker_y),
      .pclk(pclk), .vsync(vsync), .href(href), .data(data), .busy(busy),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   cam_stream_gen #(
      .H_ACTIVE(16), .V_ACTIVE(16), .H_BLANK(2), .VSYNC_LINES(1),
      .V_BACK(1), .V_FRONT(1), .PCLK_DIV(4)
   ) u_chk (
      .clk(clk), .reset_n(reset_n), .enable(enable_c), .pattern_sel(pattern_sel_c),
      .solid_y(8'h00), .marker_x(11'd0), .marker_y(10'd0),
      .pclk(pclk_c), .vsync(vsync_c), .href(href_c), .data(data_c), .busy(busy_c),
      .frame_done(frame_done_c), .frame_count(frame_count_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference luma, written from the pattern descriptions.
   function automatic logic [7:0] model_y(input int sel, input int x, input int y,
                                          input int sy, input int mx, input int my);
      int dx, dy;
      dx = (x > mx) ? x - mx : mx - x;
      dy = (y > my) ? y - my : my - y;
      case (sel)
         1: return ((((x / 8) + (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
         2: return 8'(sy);
`ifdef CAM_GEN_MARKER_EN
         3: return (dx <= 1 && dy <= 1) ? 8'hFF : 8'h10;
`endif
         default: return 8'(x % 256);
      endcase
   endfunction

   // Sample both streams at pclk rising edges, checked against the scoreboards.
   always @(negedge clk) begin
      if (pclk && !pclk_d && mon_en) begin
         if (vsync) vs_cnt++;
         if (href) begin
            if (exp_q.size() == 0) check("small_extra_byte", 32'(href), 32'd0);
            else                   check("small_byte", 32'(data), 32'(exp_q.pop_front()));
         end else begin
            check("small_blank_data", 32'(data), 32'd0);
         end
      end
      pclk_d = pclk;
      if (frame_done) done_cnt++;
   end

   always @(negedge clk) begin
      if (pclk_c && !pclk_dc) begin
         if (href_c) begin
            if (exp_qc.size() == 0) check("chk_extra_byte", 32'(href_c), 32'd0);
            else                    check("chk_byte", 32'(data_c), 32'(exp_qc.pop_front()));
         end else begin
            check("chk_blank_data", 32'(data_c), 32'd0);
         end
      end
      pclk_dc = pclk_c;
      if (frame_done_c) done_cnt_c++;
   end

   // One frame on the small raster; enable drops during VBACK, controls change mid-frame.
   task automatic run_small_frame(input int sel, input int sy, input int mx, input int my,
                                  input int exp_count);
      bit ok;
      int base;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++) begin
            exp_q.push_back(model_y(sel, x, y, sy, mx, my));
            exp_q.push_back(8'h80);
         end
      vs_cnt      = 0;
      base        = done_cnt;
      pattern_sel = 2'(sel);
      solid_y     = 8'(sy);
      marker_x    = 11'(mx);
      marker_y    = 10'(my);
      enable      = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (vsync) begin ok = 1'b1; break; end
      end
      check("vsync_rise", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!vsync) begin ok = 1'b1; break; end
      end
      check("vsync_fall", 32'(ok), 32'd1);
      enable      = 1'b0;
      pattern_sel = ~pattern_sel;
      solid_y     = ~solid_y;
      marker_x    = marker_x + 11'd1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_done) begin ok = 1'b1; break; end
      end
      check("frame_done_seen", 32'(ok), 32'd1);
      repeat (6) @(negedge clk);
      check("vsync_ticks", 32'(vs_cnt), 32'd10);
      check("done_pulses", 32'(done_cnt - base), 32'd1);
      check("frame_count", 32'(frame_count), 32'(exp_count));
      check("busy_idle", 32'(busy), 32'd0);
      check("bytes_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bit   ok;
      int   rises, highs, base;
      logic outs;

      reset_n       = 1'b0;
      enable        = 1'b0;
      pattern_sel   = 2'd0;
      solid_y       = 8'h00;
      marker_x      = 11'd0;
      marker_y      = 10'd0;
      enable_c      = 1'b0;
      pattern_sel_c = 2'd1;

      repeat (4) @(negedge clk);
      check("rst_pclk", 32'(pclk), 32'd0);
      check("rst_vsync", 32'(vsync), 32'd0);
      check("rst_href", 32'(href), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);

      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Idle: pclk toggles every clk, stream outputs stay low.
      rises = 0;
      outs  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         logic prev;
         prev = pclk;
         @(negedge clk);
         if (pclk && !prev) rises++;
         outs = outs | vsync | href | (|data) | busy;
      end
      check("idle_pclk_rises", 32'(rises), 32'd10);
      check("idle_outputs", 32'(outs), 32'd0);

      run_small_frame(0, 0, 0, 0, 1);
      run_small_frame(3, 0, 2, 1, 2);
      run_small_frame(2, 8'h5A, 0, 0, 3);

      // Checker raster: pclk period 4 clk, half high.
      rises = 0;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         logic prev;
         prev = pclk_c;
         @(negedge clk);
         if (pclk_c && !prev) rises++;
         if (pclk_c) highs++;
      end
      check("chk_pclk_rises", 32'(rises), 32'd10);
      check("chk_pclk_high", 32'(highs), 32'd20);

      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) begin
            exp_qc.push_back(model_y(1, x, y, 0, 0, 0));
            exp_qc.push_back(8'h80);
         end
      base     = done_cnt_c;
      enable_c = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (vsync_c) begin ok = 1'b1; break; end
      end
      check("chk_vsync_rise", 32'(ok), 32'd1);
      enable_c = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (frame_done_c) begin ok = 1'b1; break; end
      end
      check("chk_frame_done", 32'(ok), 32'd1);
      repeat (10) @(negedge clk);
      check("chk_done_pulses", 32'(done_cnt_c - base), 32'd1);
      check("chk_frame_count", 32'(frame_count_c), 32'd1);
      check("chk_busy", 32'(busy_c), 32'd0);
      check("chk_bytes_left", 32'(exp_qc.size()), 32'd0);

      // Mid-frame reset during ACTIVE clears outputs without a clk edge.
      mon_en      = 1'b0;
      pattern_sel = 2'd0;
      solid_y     = 8'hFF;
      enable      = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (href && data != 8'h00) begin ok = 1'b1; break; end
      end
      check("mid_href_seen", 32'(ok), 32'd1);
      base = done_cnt;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_href", 32'(href), 32'd0);
      check("mid_rst_vsync", 32'(vsync), 32'd0);
      check("mid_rst_data", 32'(data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_count", 32'(frame_count), 32'd0);
      enable = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_rst_no_done", 32'(done_cnt - base), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
